uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Serial receive front end for the UART path: synchronises the asynchronous `iRx` line, detects the start bit, samples each bit at mid-bit, and assembles a WORD_LENGTH-bit frame: data, even-parity bit, stop bit. It sits directly upstream of the even-parity checker. `oFrame` drives the checker's data input, and `oValid` drives its enable, so the parity error is qualified only on the cycle a new frame is presented.

## Interface
- `WORD_LENGTH`, default 10: bits captured after the start bit. `WORD_LENGTH-2` data bits, plus 1 parity bit, plus 1 stop bit. Minimum 3.
- `CLKS_PER_BIT`, default 434: clock cycles per bit (50 MHz / 115200). Must be an even number ≥ 4.
- `clk`  input  1: single clock; everything is on the rising edge.
- `reset`  input  1: asynchronous, active-low reset.
- `iRx`  input  1: serial line. Idles high; asynchronous to `clk`.
- `oFrame`  output  WORD_LENGTH: last captured frame.
  - `[WORD_LENGTH-1]` = stop bit.
  - `[WORD_LENGTH-2:1]` = data, first-received bit (LSB) at bit 1.
  - `[0]` = parity bit.
- `oValid`  output  1: one-cycle pulse when `oFrame` is updated.
- `oFramingError`  output  1: stop bit sampled low. Valid on the `oValid` cycle, held until the next `oValid`.
- `oBusy`  output  1: high in any state other than IDLE.

## Operation
- Input synchroniser: `iRx` passes through two flops to give `rxSync`. Both flops reset to 1.
- State machine: IDLE, START, SHIFT, STOP, BREAK.
  - **IDLE**: waiting for the line. When `rxSync`=0, go to START and clear the bit-timer.
  - **START**: the bit-timer counts to `CLKS_PER_BIT/2 - 1`, then `rxSync` is sampled.
    - If `rxSync`=1, it was a glitch: return to IDLE with no output.
    - If `rxSync`=0: go to SHIFT, clear the bit-timer and the bit index.
  - **SHIFT**: each time the bit-timer reaches `CLKS_PER_BIT - 1`, sample `rxSync` into a shift register, clear the timer, and increment the index.
    - The shift register shifts right and enters at the MSB. After WORD_LENGTH samples, the first data bit is at bit 1 and the stop bit is at MSB.
    - After sample number `WORD_LENGTH-1` (the parity bit), go to STOP.
  - **STOP**: on the next bit-timer terminal count, sample the stop bit and load the full word into `oFrame`. Pulse `oValid` on the same edge, and set `oFramingError = ~stopSample`.
    - Stop bit = 1: return to IDLE.
    - Stop bit = 0: go to BREAK.
  - **BREAK**: wait until `rxSync`=1, then go to IDLE. No start detection occurs while in BREAK.
- Parity is not evaluated here. The bit is passed through; checking it is the downstream stage's job.
- `oFrame` and `oFramingError` hold their values between frames.

## Timing
- Reset values:
  - `oFrame`=0, `oValid`=0, `oFramingError`=0, `oBusy`=0.
  - State=IDLE, timers and index=0, synchroniser=1.
- Start-edge detection latency: 2 cycles after `iRx` falls (synchroniser), plus 1 cycle to enter START.
- Sample points:
  - Start bit: `CLKS_PER_BIT/2` cycles after entering START.
  - Each following bit: `CLKS_PER_BIT` cycles after the previous sample.
- `oValid` latency: asserts exactly `CLKS_PER_BIT/2 + WORD_LENGTH*CLKS_PER_BIT` cycles after START entry. It is high for exactly 1 cycle.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. A start edge arriving at or after the end of the stop bit must be detected; no idle gap beyond the stop bit is required.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial frame is discarded, with no `oValid`. After release, the first valid frame is received normally.
- Bit-timer width: `$clog2(CLKS_PER_BIT)`. Bit-index width: `$clog2(WORD_LENGTH+1)`.

## Structure
- Shared UART package holds:
  - the state enumeration type;
  - default `CLKS_PER_BIT` and `WORD_LENGTH` constants, shared with the transmitter and the parity checker.
- Sub-module `bit_timer`: a counter with clear input and terminal-count (`CLKS_PER_BIT - 1`) output. It is reused by the transmitter.
- Everything else (synchroniser, FSM, shift register) lives in this module.

## Test plan
All scenarios use `CLKS_PER_BIT`=8 and `WORD_LENGTH`=10.
- Reset: hold `reset`=0 → all outputs 0. Release with `iRx`=1 for 100 cycles → `oBusy`=0 and no `oValid`.
- Single frame: data 0xA5, parity 0, stop 1 → one `oValid` pulse 84 cycles after START entry, `oFrame`=10'h34A, `oFramingError`=0.
- Back-to-back frames: 0xA5 then 0x07 (parity 1), no idle gap → two `oValid` pulses, `oFrame`=10'h34A then 10'h20F.
- Glitch rejection: `iRx` low for 2 cycles only → returns to IDLE, no `oValid`, `oBusy` drops within 8 cycles.
- Framing error and break: send 0x3C with stop bit 0, then hold `iRx` low 40 cycles → one `oValid` with `oFramingError`=1, no further `oValid` during the low period. After `iRx` returns high, the next frame 0x3C (stop 1) gives `oFrame`=10'h278 and `oFramingError`=0.
- Reset mid-frame: assert `reset` during data bit 3 → outputs 0 immediately, no `oValid`. After release, frame 0xFF gives `oFrame`=10'h3FE.

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: receiver state encoding and default link parameters
// used by the receiver, transmitter and parity checker.
package uart_rx_frame_pkg;

    localparam int unsigned DefaultClksPerBit = 434;  // 50 MHz / 115200
    localparam int unsigned DefaultWordLength = 10;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StShift,
        StStop,
        StBreak
    } rxState_t;

endpackage

// File: rtl/uart_rx_frame_bit_timer.sv
// Free-running bit-period counter with synchronous clear; wraps to zero on its
// terminal count so consecutive bit periods need no explicit restart.
module uart_rx_frame_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = uart_rx_frame_pkg::DefaultClksPerBit,
    localparam int unsigned CountWidth = $clog2(CLKS_PER_BIT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    output logic [CountWidth-1:0] count,
    output logic                  terminal
);

    assign terminal = (count == CountWidth'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || terminal) begin
            count <= '0;
        end else begin
            count <= count + CountWidth'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive front end: synchronises iRx, qualifies the start bit at mid-bit
// and assembles {stop, data, parity} for the downstream parity checker.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int unsigned WORD_LENGTH  = DefaultWordLength,
    parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   iRx,
    output logic [WORD_LENGTH-1:0] oFrame,
    output logic                   oValid,
    output logic                   oFramingError,
    output logic                   oBusy
);

    localparam int unsigned TimerWidth = $clog2(CLKS_PER_BIT);
    localparam int unsigned IndexWidth = $clog2(WORD_LENGTH + 1);
    localparam int unsigned HalfCount  = CLKS_PER_BIT / 2 - 1;

    rxState_t                state;
    logic                    rxMeta;
    logic                    rxSync;
    logic [TimerWidth-1:0]   timerCount;
    logic                    timerTerminal;
    logic                    timerClear;
    logic                    halfTerminal;
    logic [IndexWidth-1:0]   bitIndex;
    logic [WORD_LENGTH-2:0]  shiftReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= iRx;
            rxSync <= rxMeta;
        end
    end

    assign halfTerminal = (timerCount == TimerWidth'(HalfCount));
    // Held clear while idle so START always begins counting from zero.
    assign timerClear   = (state == StIdle) || ((state == StStart) && halfTerminal);
    assign oBusy        = (state != StIdle);

    uart_rx_frame_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) bitTimer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timerClear),
        .count    (timerCount),
        .terminal (timerTerminal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            bitIndex      <= '0;
            shiftReg      <= '0;
            oFrame        <= '0;
            oValid        <= 1'b0;
            oFramingError <= 1'b0;
        end else begin
            oValid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (!rxSync) state <= StStart;
                end
                StStart: begin
                    if (halfTerminal) begin
                        if (rxSync) begin
                            state <= StIdle;
                        end else begin
                            state    <= StShift;
                            bitIndex <= '0;
                        end
                    end
                end
                StShift: begin
                    if (timerTerminal) begin
                        shiftReg <= {rxSync, shiftReg[WORD_LENGTH-2:1]};
                        bitIndex <= bitIndex + IndexWidth'(1);
                        if (bitIndex == IndexWidth'(WORD_LENGTH - 2)) state <= StStop;
                    end
                end
                StStop: begin
                    if (timerTerminal) begin
                        // Parity arrives last but is presented at bit 0.
                        oFrame        <= {rxSync, shiftReg[WORD_LENGTH-3:0],
                                          shiftReg[WORD_LENGTH-2]};
                        oValid        <= 1'b1;
                        oFramingError <= ~rxSync;
                        state         <= rxSync ? StIdle : StBreak;
                    end
                end
                StBreak: begin
                    if (rxSync) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: frames are driven bit-serially and
// their expected words queued; a monitor pops and checks on every oValid.
module tb_uart_rx_frame;

    localparam int unsigned Wl      = 10;
    localparam int unsigned Cpb     = 8;
    localparam int unsigned Latency = 87;  // fall -> sync(2) + START entry(1) + 84

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          iRx = 1'b1;
    logic [Wl-1:0] oFrame;
    logic          oValid;
    logic          oFramingError;
    logic          oBusy;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cycle = 0;
    int unsigned validCount = 0;
    logic        prevValid = 1'b0;

    logic [Wl-1:0] expFrame[$];
    logic          expFe[$];
    int unsigned   expStart[$];

    uart_rx_frame #(
        .WORD_LENGTH  (Wl),
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .iRx           (iRx),
        .oFrame        (oFrame),
        .oValid        (oValid),
        .oFramingError (oFramingError),
        .oBusy         (oBusy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkEq(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    always @(negedge clk) begin
        if (prevValid) checkEq("pulseWidth", 32'(oValid), 32'd0);
        prevValid = oValid;
        if (oValid) begin
            validCount++;
            if (expFrame.size() == 0) begin
                checkEq("spuriousValid", 32'(expFrame.size()), 32'd1);
            end else begin
                logic [Wl-1:0] f;
                logic          fe;
                int unsigned   s;
                f  = expFrame.pop_front();
                fe = expFe.pop_front();
                s  = expStart.pop_front();
                checkEq("frame", 32'(oFrame), 32'(f));
                checkEq("framingError", 32'(oFramingError), 32'(fe));
                checkEq("latency", cycle - s, Latency);
            end
        end
    end

    // Called at a falling edge; holds the line for one bit period.
    task automatic driveBit(input logic b);
        iRx = b;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] data, input logic stopBit);
        logic parity;
        parity = ^data;
        expFrame.push_back({stopBit, data, parity});
        expFe.push_back(~stopBit);
        expStart.push_back(cycle);
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
        driveBit(parity);
        driveBit(stopBit);
    endtask

    initial begin
        int unsigned snap;

        // Reset state
        repeat (3) @(negedge clk);
        checkEq("rstFrame", 32'(oFrame), 32'd0);
        checkEq("rstValid", 32'(oValid), 32'd0);
        checkEq("rstFe", 32'(oFramingError), 32'd0);
        checkEq("rstBusy", 32'(oBusy), 32'd0);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        checkEq("idleBusy", 32'(oBusy), 32'd0);
        checkEq("idleValids", validCount, 32'd0);

        // Single frame, then back-to-back pair with no idle gap
        sendFrame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        sendFrame(8'hA5, 1'b1);
        sendFrame(8'h07, 1'b1);
        repeat (20) @(negedge clk);
        checkEq("b2bValids", validCount, 32'd3);

        // Glitch rejection
        snap = validCount;
        iRx = 1'b0;
        repeat (2) @(negedge clk);
        iRx = 1'b1;
        repeat (3) @(negedge clk);
        checkEq("glitchBusyHigh", 32'(oBusy), 32'd1);
        repeat (5) @(negedge clk);
        checkEq("glitchBusyLow", 32'(oBusy), 32'd0);
        repeat (10) @(negedge clk);
        checkEq("glitchValids", validCount, snap);

        // Framing error followed by a held-low break
        snap = validCount;
        sendFrame(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        checkEq("breakValids", validCount, snap + 1);
        checkEq("breakBusy", 32'(oBusy), 32'd1);
        checkEq("breakFe", 32'(oFramingError), 32'd1);
        iRx = 1'b1;
        repeat (16) @(negedge clk);
        checkEq("breakExitBusy", 32'(oBusy), 32'd0);
        sendFrame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);

        // Reset asserted during data bit 3
        snap = validCount;
        driveBit(1'b0);
        for (int i = 0; i < 3; i++) driveBit(1'b1);
        iRx = 1'b1;
        repeat (Cpb / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkEq("midRstFrame", 32'(oFrame), 32'd0);
        checkEq("midRstValid", 32'(oValid), 32'd0);
        checkEq("midRstFe", 32'(oFramingError), 32'd0);
        checkEq("midRstBusy", 32'(oBusy), 32'd0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checkEq("midRstValids", validCount, snap);
        sendFrame(8'hFF, 1'b1);

        // Drain with a bounded wait
        for (int i = 0; i < 200 && expFrame.size() != 0; i++) @(negedge clk);
        checkEq("drain", 32'(expFrame.size()), 32'd0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
